// File: rtl/ram_porta_arbiter.sv
// ram_porta_arbiter
// -----------------
// Arbitrates two requesters onto RAM_Interface port A (byte-addressable
// data port, one-cycle read latency). Requester 0 is the core load/store
// path; requester 1 is an auxiliary master (UART loader / debug).
// One command is granted per cycle, and the granted command is registered
// onto the RAM port. Read data is steered back to the requester that
// issued the read, together with an rvalid strobe two cycles after grant.
//
// Configuration macro:
//   ARB_RR_EN  defined   -> round-robin arbitration on ties (1-bit pointer)
//              undefined -> fixed priority (m0 first) with a starvation
//                           guard that force-grants m1 after STARVE_LIMIT
//                           consecutive waiting cycles
//
// Parameters:
//   STARVE_LIMIT  cycles m1 may wait before it is force-granted (1..15)
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m0_*/m1_* req,we,re,addr,din   requester commands (held until gnt)
//   m0_gnt, m1_gnt             combinational accept strobes
//   m0_rvalid, m1_rvalid       read data valid for that requester
//   m0_rdata, m1_rdata         read data (mirror of ram_doutA)
//   ram_weA, ram_reA,
//   ram_addrA, ram_dinA        registered RAM port A command
//   ram_doutA                  RAM read data, one cycle after command

module ram_porta_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [1:0]  m0_we,
    input  logic [2:0]  m0_re,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_din,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic [1:0]  m1_we,
    input  logic [2:0]  m1_re,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_din,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [1:0]  ram_weA,
    output logic [2:0]  ram_reA,
    output logic [31:0] ram_addrA,
    output logic [31:0] ram_dinA,
    input  logic [31:0] ram_doutA
);

    // Selected (granted) command
    logic        any_gnt;
    logic [1:0]  sel_we;
    logic [2:0]  sel_re;
    logic [31:0] sel_addr;
    logic [31:0] sel_din;
    logic        is_write;
    logic        is_read;

    // Read-owner pipeline: stage 1 aligns with the command on ram_*,
    // stage 2 aligns with ram_doutA.
    logic        s1_valid;
    logic        s1_id;
    logic        s2_valid;
    logic        s2_id;

`ifdef ARB_RR_EN
    // 1 = m1 was granted most recently; reset value makes m0 win first tie
    logic        last_m1;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0]  wait_cnt;
    logic        starve;

    assign starve = (wait_cnt == LIMIT);
`endif

    // Grant decision. Nothing is granted while rst is high.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!rst) begin
            if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
                if (last_m1) begin
                    m0_gnt = 1'b1;
                end else begin
                    m1_gnt = 1'b1;
                end
`else
                if (starve) begin
                    m1_gnt = 1'b1;
                end else begin
                    m0_gnt = 1'b1;
                end
`endif
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    // Command mux. A write wins over a read in an illegal both-set command.
    always_comb begin
        any_gnt  = m0_gnt | m1_gnt;
        sel_we   = m1_gnt ? m1_we   : m0_we;
        sel_re   = m1_gnt ? m1_re   : m0_re;
        sel_addr = m1_gnt ? m1_addr : m0_addr;
        sel_din  = m1_gnt ? m1_din  : m0_din;
        is_write = any_gnt && (sel_we != 2'b00);
        is_read  = any_gnt && (sel_we == 2'b00) && (sel_re != 3'b000);
    end

    // RAM port register. Idle and no-op grants drive the port to all zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_weA   <= '0;
            ram_reA   <= '0;
            ram_addrA <= '0;
            ram_dinA  <= '0;
        end else if (is_write) begin
            ram_weA   <= sel_we;
            ram_reA   <= '0;
            ram_addrA <= sel_addr;
            ram_dinA  <= sel_din;
        end else if (is_read) begin
            ram_weA   <= '0;
            ram_reA   <= sel_re;
            ram_addrA <= sel_addr;
            ram_dinA  <= '0;
        end else begin
            ram_weA   <= '0;
            ram_reA   <= '0;
            ram_addrA <= '0;
            ram_dinA  <= '0;
        end
    end

    // Owner pipeline; clearing both stages on reset drops reads in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s2_valid <= 1'b0;
            s2_id    <= 1'b0;
        end else begin
            s1_valid <= is_read;
            s1_id    <= m1_gnt;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
        end
    end

`ifdef ARB_RR_EN
    // Pointer follows every grant, including no-op grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_m1 <= 1'b1;
        end else if (any_gnt) begin
            last_m1 <= m1_gnt;
        end
    end
`else
    // Count consecutive cycles m1 has been kept waiting, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!m1_req || m1_gnt) begin
            wait_cnt <= '0;
        end else if (!starve) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    // Response steering
    always_comb begin
        m0_rvalid = s2_valid && !s2_id;
        m1_rvalid = s2_valid &&  s2_id;
        m0_rdata  = ram_doutA;
        m1_rdata  = ram_doutA;
    end

endmodule

// File: tb/tb_ram_porta_arbiter.sv
// Testbench for ram_porta_arbiter: a behavioural RAM drives ram_doutA, and a
// transaction-level reference model (grant rule, queue of expected read
// returns, shadow memory) predicts every output each cycle. Directed
// scenarios are followed by a randomized phase.

module tb_ram_porta_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [1:0]  m0_we, m1_we;
    logic [2:0]  m0_re, m1_re;
    logic [31:0] m0_addr, m1_addr, m0_din, m1_din;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  ram_weA;
    logic [2:0]  ram_reA;
    logic [31:0] ram_addrA, ram_dinA;
    logic [31:0] ram_doutA = '0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ram_porta_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_re(m0_re), .m0_addr(m0_addr),
        .m0_din(m0_din), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_re(m1_re), .m1_addr(m1_addr),
        .m1_din(m1_din), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_weA(ram_weA), .ram_reA(ram_reA), .ram_addrA(ram_addrA),
        .ram_dinA(ram_dinA), .ram_doutA(ram_doutA)
    );

    // Byte-lane helpers shared by the RAM model and the shadow memory
    function automatic logic [31:0] loadVal(logic [31:0] w, logic [31:0] a, logic [2:0] re);
        logic [31:0] s;
        s = w >> (8 * a[1:0]);
        case (re[1:0])
            2'b01:   return re[2] ? {{24{s[7]}}, s[7:0]}   : {24'b0, s[7:0]};
            2'b10:   return re[2] ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] storeVal(logic [31:0] old, logic [31:0] a,
                                             logic [1:0] we, logic [31:0] d);
        logic [31:0] m;
        int sh;
        sh = 8 * a[1:0];
        case (we)
            2'b01:   m = 32'h0000_00FF << sh;
            2'b10:   m = 32'h0000_FFFF << sh;
            default: return d;
        endcase
        return (old & ~m) | ((d << sh) & m);
    endfunction

    // Behavioural RAM port A
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (ram_weA != 2'b00)
            mem[ram_addrA[9:2]] <= storeVal(mem[ram_addrA[9:2]], ram_addrA, ram_weA, ram_dinA);
        else if (ram_reA != 3'b000)
            ram_doutA <= loadVal(mem[ram_addrA[9:2]], ram_addrA, ram_reA);
    end

    // Reference model state
    typedef struct { int due; bit id; logic [31:0] data; } ret_t;
    ret_t        pend[$];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          m1_waited = 0;
    bit          last_was_m1 = 1'b1;
    logic [1:0]  exp_we = '0;
    logic [2:0]  exp_re = '0;
    logic [31:0] exp_addr = '0, exp_din = '0;
    bit          last_g0, last_g1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic applyStimulus(input bit id, input bit req, input logic [1:0] we,
                                 input logic [2:0] re, input logic [31:0] addr,
                                 input logic [31:0] din);
        if (id) begin
            m1_req = req; m1_we = we; m1_re = re; m1_addr = addr; m1_din = din;
        end else begin
            m0_req = req; m0_we = we; m0_re = re; m0_addr = addr; m0_din = din;
        end
    endtask

    // One clock cycle: predict and check at the falling edge, then advance
    // the model on the rising edge. Returns 1 ns after the rising edge.
    task automatic stepCycle();
        bit g0, g1, v0, v1, g;
        logic [1:0]  we;
        logic [2:0]  re;
        logic [31:0] a, d;
        @(negedge clk);
        g0 = 0; g1 = 0;
        if (!rst) begin
            if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
                if (last_was_m1) g0 = 1; else g1 = 1;
`else
                if (m1_waited >= LIMIT) g1 = 1; else g0 = 1;
`endif
            end else begin
                g0 = m0_req; g1 = m1_req;
            end
        end
        v0 = pend.size() > 0 && pend[0].due == cyc && pend[0].id == 1'b0;
        v1 = pend.size() > 0 && pend[0].due == cyc && pend[0].id == 1'b1;
        checkOutput("m0_gnt", 32'(m0_gnt), 32'(g0));
        checkOutput("m1_gnt", 32'(m1_gnt), 32'(g1));
        checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(v0));
        checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(v1));
        if (v0) checkOutput("m0_rdata", m0_rdata, pend[0].data);
        if (v1) checkOutput("m1_rdata", m1_rdata, pend[0].data);
        checkOutput("ram_weA", 32'(ram_weA), 32'(exp_we));
        checkOutput("ram_reA", 32'(ram_reA), 32'(exp_re));
        checkOutput("ram_addrA", ram_addrA, exp_addr);
        checkOutput("ram_dinA", ram_dinA, exp_din);
        last_g0 = g0; last_g1 = g1;
        @(posedge clk);
        if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
        if (rst) begin
            pend.delete();
            m1_waited = 0; last_was_m1 = 1'b1;
            exp_we = '0; exp_re = '0; exp_addr = '0; exp_din = '0;
        end else begin
            m1_waited = (m1_req && !g1) ? ((m1_waited + 1 > LIMIT) ? LIMIT : m1_waited + 1) : 0;
            g = g0 || g1;
            if (g) last_was_m1 = g1;
            we = g1 ? m1_we : m0_we;   re = g1 ? m1_re : m0_re;
            a  = g1 ? m1_addr : m0_addr; d = g1 ? m1_din : m0_din;
            exp_we = '0; exp_re = '0; exp_addr = '0; exp_din = '0;
            if (g && we != 2'b00) begin
                exp_we = we; exp_addr = a; exp_din = d;
                ref_mem[a[9:2]] = storeVal(ref_mem[a[9:2]], a, we, d);
            end else if (g && re != 3'b000) begin
                exp_re = re; exp_addr = a;
                pend.push_back('{due: cyc + 2, id: g1, data: loadVal(ref_mem[a[9:2]], a, re)});
            end
        end
        #1;
        cyc++;
    endtask

    task automatic idleBoth();
        applyStimulus(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
        applyStimulus(1, 0, 2'b00, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'(i) * 32'h0101_0101;
            ref_mem[i] = mem[i];
        end
        mem[0]  = 32'h0000_0011; ref_mem[0]  = 32'h0000_0011;
        mem[1]  = 32'h0000_2200; ref_mem[1]  = 32'h0000_2200;
        mem[64] = 32'hDEAD_BEEF; ref_mem[64] = 32'hDEAD_BEEF;

        // Reset with both requesting: no grants, outputs zero
        rst = 1'b1;
        applyStimulus(0, 1, 2'b00, 3'b111, 32'h100, 32'h0);
        applyStimulus(1, 1, 2'b11, 3'b000, 32'h40, 32'h1234);
        repeat (2) stepCycle();
        idleBoth();
        rst = 1'b0;
        stepCycle();

        // Single read by m0
        applyStimulus(0, 1, 2'b00, 3'b111, 32'h100, 32'h0);
        #1 checkOutput("single_gnt", 32'(m0_gnt), 32'd1);
        stepCycle();
        idleBoth();
        checkOutput("single_reA", 32'(ram_reA), 32'h7);
        checkOutput("single_addr", ram_addrA, 32'h100);
        stepCycle();
        checkOutput("single_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("single_rdata", m0_rdata, 32'hDEAD_BEEF);
        checkOutput("single_m1_rvalid", 32'(m1_rvalid), 32'd0);
        stepCycle();

        // Continuous contention with no-op commands
        applyStimulus(0, 1, 2'b00, 3'b000, 32'h0, 32'h0);
        applyStimulus(1, 1, 2'b00, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
`ifdef ARB_RR_EN
            checkOutput("rr_pattern", 32'(m1_gnt), 32'(i % 2 == 0));
`else
            checkOutput("fp_pattern", 32'(m1_gnt), 32'(i % 5 == 4));
`endif
            stepCycle();
        end
        idleBoth();
        stepCycle();

        // Interleaved returns
        applyStimulus(0, 1, 2'b00, 3'b011, 32'h0, 32'h0);
        stepCycle();
        applyStimulus(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
        applyStimulus(1, 1, 2'b00, 3'b001, 32'h5, 32'h0);
        stepCycle();
        idleBoth();
        checkOutput("il_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkOutput("il_m0_rdata", m0_rdata, 32'h11);
        stepCycle();
        checkOutput("il_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkOutput("il_m1_rdata", m1_rdata, 32'h22);
        stepCycle();

        // Write then read by m1
        applyStimulus(1, 1, 2'b11, 3'b000, 32'h40, 32'hCAFE_F00D);
        stepCycle();
        applyStimulus(1, 1, 2'b00, 3'b011, 32'h40, 32'h0);
        stepCycle();
        idleBoth();
        checkOutput("wr_no_rvalid", 32'(m1_rvalid), 32'd0);
        stepCycle();
        checkOutput("wr_rdata", m1_rdata, 32'hCAFE_F00D);
        stepCycle();

        // Illegal command: write forwarded, read dropped
        applyStimulus(0, 1, 2'b11, 3'b111, 32'h80, 32'h5555_AAAA);
        stepCycle();
        idleBoth();
        checkOutput("ill_weA", 32'(ram_weA), 32'h3);
        checkOutput("ill_reA", 32'(ram_reA), 32'h0);
        repeat (2) stepCycle();

        // Reset in the cycle after a read grant
        applyStimulus(0, 1, 2'b00, 3'b111, 32'h100, 32'h0);
        stepCycle();
        applyStimulus(0, 0, 2'b00, 3'b000, 32'h0, 32'h0);
        applyStimulus(1, 1, 2'b00, 3'b111, 32'h8, 32'h0);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        idleBoth();
        checkOutput("rst_reA", 32'(ram_reA), 32'h0);
        checkOutput("rst_rvalid", 32'(m0_rvalid), 32'd0);
        stepCycle();
        checkOutput("rst_rvalid2", 32'(m0_rvalid), 32'd0);
        applyStimulus(0, 1, 2'b00, 3'b111, 32'h100, 32'h0);
        #1 checkOutput("rst_resume_gnt", 32'(m0_gnt), 32'd1);
        stepCycle();
        idleBoth();
        repeat (3) stepCycle();

        // Randomized traffic; commands held until granted
        for (int i = 0; i < 400; i++) begin
            if (!m0_req || last_g0)
                applyStimulus(0, ($urandom % 4) != 0,
                              ($urandom % 3 == 0) ? 2'($urandom) : 2'b00,
                              3'($urandom), 32'($urandom_range(0, 1023)), $urandom);
            if (!m1_req || last_g1)
                applyStimulus(1, ($urandom % 3) != 0,
                              ($urandom % 3 == 0) ? 2'($urandom) : 2'b00,
                              3'($urandom), 32'($urandom_range(0, 1023)), $urandom);
            if (i % 97 == 50) rst = 1'b1;
            stepCycle();
            rst = 1'b0;
        end
        idleBoth();
        repeat (3) stepCycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
